frame_serializer: RTL and testbench

FRAME_SERIALIZER -- requirements
Module: frame_serializer

---
 rtl/frame_serializer.sv | 98 +++++++++
 tb/tb_frame_serializer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_serializer.sv
// Frame serializer: captures an N-sample frame and streams it out
// as LANES-wide beats, in natural or bit-reversed sample order.
module frame_serializer #(
  parameter int DW    = 13,
  parameter int N     = 512,
  parameter int LANES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*DW-1:0]       din,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  bitrev_mode,
  output logic [LANES*DW-1:0]   dout,
  output logic                  do_en,
  input  logic                  dout_ready,
  output logic                  frame_done
);

  localparam int BEATS = N / LANES;
  localparam int IW    = $clog2(N);
  localparam int CW    = $clog2(BEATS);
  localparam int KW    = $clog2(LANES);

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int b = 0; b < IW; b++) r[b] = v[IW-1-b];
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          cap, acc, last;
  logic [DW-1:0] frame_q [N];

  assign last = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in && !rst) begin
          cap     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dout_ready && !rst) begin
          acc = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= acc && last;
      if (cap)      cnt_q <= '0;
      else if (acc) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bit-reversal is applied while capturing, so readout is always linear.
  for (genvar i = 0; i < N; i++) begin : g_cap
    localparam int R = int'(bitrev(IW'(i)));
    always_ff @(posedge clk) begin
      if (cap) begin
        frame_q[i] <= bitrev_mode ? din[R*DW +: DW]
                                  : din[i*DW +: DW];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_out
    logic [IW-1:0] idx;
    assign idx = {cnt_q, KW'(k)};
    assign dout[k*DW +: DW] = (state_q == SEND) ? frame_q[idx]
                                                : '0;
  end

  assign ready_in   = (state_q == IDLE);
  assign do_en      = (state_q == SEND);
  assign frame_done = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: natural/bit-reversed order,
// stalls, back-to-back frames, abort by reset and signed samples.
module tb_frame_serializer;

  localparam int DW    = 13;
  localparam int N     = 512;
  localparam int LANES = 16;
  localparam int BEATS = N / LANES;

  logic                clk;
  logic                rst;
  logic [N*DW-1:0]     din;
  logic                valid_in;
  logic                ready_in;
  logic                bitrev_mode;
  logic [LANES*DW-1:0] dout;
  logic                do_en;
  logic                dout_ready;
  logic                frame_done;

  int checks;
  int errors;

  frame_serializer #(.DW(DW), .N(N), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .bitrev_mode(bitrev_mode),
    .dout       (dout),
    .do_en      (do_en),
    .dout_ready (dout_ready),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind 0: din[i]=i, kind 1: din[i]=N-1-i, kind 2: din[i]=-4096
  function automatic logic [DW-1:0] sample(input int kind, input int i);
    if (kind == 0) return DW'(i);
    if (kind == 1) return DW'(N - 1 - i);
    return DW'(-4096);
  endfunction

  function automatic int rev9(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 9; b++) r = r | (((v >> b) & 1) << (8 - b));
    return r;
  endfunction

  function automatic logic [LANES*DW-1:0] exp_beat(
    input int kind, input bit mode, input int c);
    logic [LANES*DW-1:0] v;
    int idx;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = c * LANES + k;
      if (mode) idx = rev9(idx);
      v[k*DW +: DW] = sample(kind, idx);
    end
    return v;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) din[i*DW +: DW] = sample(kind, i);
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b1; dout_ready = 1'b1;
    bitrev_mode = 1'b0; fill(0);
    tick; tick;
    checks++;
    if (ready_in !== 1'b1 || do_en !== 1'b0 ||
        frame_done !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b do_en=%b done=%b dout=%h want 1 0 0 0",
               ready_in, do_en, frame_done, dout);
    end
    rst = 1'b0; valid_in = 1'b0;
    tick;
    checks++;
    if (ready_in !== 1'b1 || do_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b do_en=%b want 1 0",
               ready_in, do_en);
    end
  endtask

  task automatic test_natural;
    fill(0); bitrev_mode = 1'b0; dout_ready = 1'b1; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    for (int c = 0; c < BEATS; c++) begin
      checks++;
      if (do_en !== 1'b1 || frame_done !== 1'b0 ||
          dout !== exp_beat(0, 1'b0, c)) begin
        errors++;
        $display("FAIL natural beat %0d: en=%b done=%b got %h want %h",
                 c, do_en, frame_done, dout, exp_beat(0, 1'b0, c));
      end
      tick;
    end
    checks++;
    if (frame_done !== 1'b1 || do_en !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL natural_done: done=%b en=%b ready=%b want 1 0 1",
               frame_done, do_en, ready_in);
    end
    tick;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL natural_pulse: done=%b want 0", frame_done);
    end
  endtask

  task automatic test_bitrev;
    int t [16] = '{0, 256, 128, 384, 64, 320, 192, 448,
                   32, 288, 160, 416, 96, 352, 224, 480};
    logic [LANES*DW-1:0] b0;
    for (int k = 0; k < LANES; k++) b0[k*DW +: DW] = DW'(t[k]);
    fill(0); bitrev_mode = 1'b1; dout_ready = 1'b1; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    fill(1); bitrev_mode = 1'b0;
    checks++;
    if (dout !== b0) begin
      errors++;
      $display("FAIL bitrev_beat0: got %h want %h", dout, b0);
    end
    for (int c = 0; c < BEATS; c++) begin
      checks++;
      if (do_en !== 1'b1 || dout !== exp_beat(0, 1'b1, c)) begin
        errors++;
        $display("FAIL bitrev beat %0d: en=%b got %h want %h",
                 c, do_en, dout, exp_beat(0, 1'b1, c));
      end
      if (c == BEATS - 1) begin
        checks++;
        if (dout[15*DW +: DW] !== DW'(511)) begin
          errors++;
          $display("FAIL bitrev_last_lane: got %0d want 511",
                   dout[15*DW +: DW]);
        end
      end
      tick;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bitrev_done: got %b want 1", frame_done);
    end
    tick;
  endtask

  task automatic test_stall;
    int eb;
    bit acc;
    eb = 0;
    fill(0); bitrev_mode = 1'b0; dout_ready = 1'b0; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    for (int cyc = 0; cyc < 400 && frame_done !== 1'b1; cyc++) begin
      if (do_en === 1'b1) begin
        checks++;
        if (eb >= BEATS || dout !== exp_beat(0, 1'b0, eb)) begin
          errors++;
          $display("FAIL stall beat %0d: got %h", eb, dout);
        end
      end
      dout_ready = 1'($urandom_range(0, 1));
      acc = (do_en === 1'b1) && dout_ready;
      tick;
      if (acc) eb++;
    end
    checks++;
    if (frame_done !== 1'b1 || eb != BEATS) begin
      errors++;
      $display("FAIL stall_total: done=%b beats=%0d want 1 %0d",
               frame_done, eb, BEATS);
    end
    dout_ready = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    fill(0); bitrev_mode = 1'b0; dout_ready = 1'b1; valid_in = 1'b1;
    tick;
    fill(1); bitrev_mode = 1'b1;
    for (int c = 0; c < BEATS; c++) begin
      checks++;
      if (do_en !== 1'b1 || dout !== exp_beat(0, 1'b0, c)) begin
        errors++;
        $display("FAIL b2b_a beat %0d: en=%b got %h want %h",
                 c, do_en, dout, exp_beat(0, 1'b0, c));
      end
      tick;
    end
    checks++;
    if (frame_done !== 1'b1 || ready_in !== 1'b1 || do_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: done=%b ready=%b en=%b want 1 1 0",
               frame_done, ready_in, do_en);
    end
    tick;
    valid_in = 1'b0;
    for (int c = 0; c < BEATS; c++) begin
      checks++;
      if (do_en !== 1'b1 || frame_done !== 1'b0 ||
          dout !== exp_beat(1, 1'b1, c)) begin
        errors++;
        $display("FAIL b2b_b beat %0d: en=%b done=%b got %h want %h",
                 c, do_en, frame_done, dout, exp_beat(1, 1'b1, c));
      end
      tick;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got %b want 1", frame_done);
    end
    tick;
  endtask

  task automatic test_abort;
    bit bad;
    bad = 1'b0;
    fill(0); bitrev_mode = 1'b0; dout_ready = 1'b1; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    repeat (11) tick;
    checks++;
    if (do_en !== 1'b1 || dout !== exp_beat(0, 1'b0, 11)) begin
      errors++;
      $display("FAIL abort_pre: en=%b got %h want %h",
               do_en, dout, exp_beat(0, 1'b0, 11));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (do_en !== 1'b0 || ready_in !== 1'b1 ||
        frame_done !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL abort: en=%b ready=%b done=%b dout=%h want 0 1 0 0",
               do_en, ready_in, frame_done, dout);
    end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (frame_done !== 1'b0 || do_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_quiet: activity after abort, got 1 want 0");
    end
    fill(1); valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    checks++;
    if (do_en !== 1'b1 || dout !== exp_beat(1, 1'b0, 0)) begin
      errors++;
      $display("FAIL abort_restart: en=%b got %h want %h",
               do_en, dout, exp_beat(1, 1'b0, 0));
    end
    for (int i = 0; i < 40 && frame_done !== 1'b1; i++) tick;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL abort_drain: done=%b want 1", frame_done);
    end
    tick;
  endtask

  task automatic test_negative;
    fill(2); bitrev_mode = 1'b0; dout_ready = 1'b1; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    checks++;
    if (dout !== exp_beat(2, 1'b0, 0)) begin
      errors++;
      $display("FAIL negative_beat: got %h want %h",
               dout, exp_beat(2, 1'b0, 0));
    end
    checks++;
    if ($signed(dout[5*DW +: DW]) != -4096) begin
      errors++;
      $display("FAIL negative_lane5: got %0d want -4096",
               $signed(dout[5*DW +: DW]));
    end
    for (int i = 0; i < 40 && frame_done !== 1'b1; i++) tick;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL negative_drain: done=%b want 1", frame_done);
    end
    tick;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; valid_in = 1'b0; dout_ready = 1'b0;
    bitrev_mode = 1'b0; din = '0;
    test_reset;
    test_natural;
    test_bitrev;
    test_stall;
    test_back_to_back;
    test_abort;
    test_negative;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
